tl_rx_error_check_ctrl: RTL

TL_RX_ERROR_CHECK_CTRL -- requirements
Module: tl_rx_error_check_ctrl

---
 rtl/tl_rx_pkg.sv | 23 ++
 rtl/tl_rx_error_check_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tl_rx_pkg.sv
// Shared definitions for the TL receive error-check controller: FSM state
// encodings and decoded TLP type codes.
package tl_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_CHECK  = 2'd2,
      ST_REPORT = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      TYP_MEMORY        = 3'b000,
      TYP_IO            = 3'b001,
      TYP_COMPLETION    = 3'b010,
      TYP_CONFIGURATION = 3'b011,
      TYP_MESSAGE       = 3'b100
   } tlp_typ_e;

   localparam int unsigned TLP_TYP_W = 3;
   localparam int unsigned MALF_CNT_W = 16;

endpackage : tl_rx_pkg

// File: rtl/tl_rx_error_check_ctrl.sv
// Tracks one received TLP, counts payload DW, triggers the malformed checker
// and reports failures. Optional TL_RX_MALF_STATS_EN adds a failure counter.
module tl_rx_error_check_ctrl
   import tl_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int BEAT_DW    = 8
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         i_tlp_start,
   input  logic [TLP_TYP_W-1:0]         i_typ,
   input  logic [DATA_WIDTH-1:0]        i_length,
   input  logic                         i_has_data,
   input  logic                         i_data_valid,
   input  logic [$clog2(BEAT_DW)-1:0]   i_data_dw,
   input  logic                         i_eop,
   input  logic                         i_malformed_error,
   output logic                         o_malformed_en,
   output logic [$clog2(BEAT_DW)-1:0]   o_last_dw,
   output logic [$clog2(BEAT_DW)-1:0]   o_last_rcv_data,
   output logic                         o_eop,
   output logic                         o_rcv_done,
   output logic                         o_busy,
`ifdef TL_RX_MALF_STATS_EN
   output logic [MALF_CNT_W-1:0]        o_malf_cnt,
`endif
   output logic                         o_err_valid,
   input  logic                         i_err_ready,
   output logic [TLP_TYP_W-1:0]         o_err_typ
);

   localparam int CW    = DATA_WIDTH + 1;
   localparam int IDX_W = $clog2(BEAT_DW);

   state_e                  state_q, state_d;
   logic [TLP_TYP_W-1:0]    typ_q, typ_d;
   logic [CW-1:0]           eff_len_q, eff_len_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]        last_dw_q, last_dw_d;
   logic [IDX_W-1:0]        last_rcv_q, last_rcv_d;
   logic                    eop_q, eop_d;
   logic                    rcv_done_q, rcv_done_d;

   logic [CW-1:0]           eff_len_in;
   logic [DATA_WIDTH-1:0]   len_m1;
   logic [CW:0]             cnt_sum;
   logic [CW-1:0]           cnt_upd;

   // Length 0 encodes 2^DATA_WIDTH DW; the minus-one wraps so its low bits give 7.
   assign eff_len_in = (i_length == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, i_length};
   assign len_m1     = i_length - DATA_WIDTH'(1);
   assign cnt_sum    = {1'b0, cnt_q} + (CW+1)'(i_data_dw) + (CW+1)'(1);
   assign cnt_upd    = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];

   always_comb begin
      state_d    = state_q;
      typ_d      = typ_q;
      eff_len_d  = eff_len_q;
      cnt_d      = cnt_q;
      last_dw_d  = last_dw_q;
      last_rcv_d = last_rcv_q;
      eop_d      = eop_q;
      rcv_done_d = rcv_done_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_tlp_start) begin
               typ_d     = i_typ;
               eff_len_d = eff_len_in;
               last_dw_d = len_m1[IDX_W-1:0];
               cnt_d     = '0;
               if (i_has_data) begin
                  last_rcv_d = '0;
                  eop_d      = 1'b0;
                  rcv_done_d = 1'b0;
                  state_d    = ST_DATA;
               end else begin
                  // No payload: make the length checks trivially agree.
                  last_rcv_d = len_m1[IDX_W-1:0];
                  eop_d      = 1'b1;
                  rcv_done_d = 1'b1;
                  state_d    = ST_CHECK;
               end
            end
         end

         ST_DATA: begin
            if (i_data_valid) begin
               cnt_d = cnt_upd;
               if (i_eop) begin
                  eop_d      = 1'b1;
                  last_rcv_d = i_data_dw;
                  rcv_done_d = (cnt_upd == eff_len_q);
                  state_d    = ST_CHECK;
               end
            end
         end

         ST_CHECK: begin
            state_d = i_malformed_error ? ST_REPORT : ST_IDLE;
         end

         ST_REPORT: begin
            if (i_err_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= ST_IDLE;
         typ_q      <= '0;
         eff_len_q  <= '0;
         cnt_q      <= '0;
         last_dw_q  <= '0;
         last_rcv_q <= '0;
         eop_q      <= 1'b0;
         rcv_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         typ_q      <= typ_d;
         eff_len_q  <= eff_len_d;
         cnt_q      <= cnt_d;
         last_dw_q  <= last_dw_d;
         last_rcv_q <= last_rcv_d;
         eop_q      <= eop_d;
         rcv_done_q <= rcv_done_d;
      end
   end

`ifdef TL_RX_MALF_STATS_EN
   logic [MALF_CNT_W-1:0] malf_cnt_q, malf_cnt_d;

   // Counts accepted error reports, sticking at all-ones.
   always_comb begin
      malf_cnt_d = malf_cnt_q;
      if ((state_q == ST_REPORT) && i_err_ready && (malf_cnt_q != {MALF_CNT_W{1'b1}})) begin
         malf_cnt_d = malf_cnt_q + MALF_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         malf_cnt_q <= '0;
      end else begin
         malf_cnt_q <= malf_cnt_d;
      end
   end

   assign o_malf_cnt = malf_cnt_q;
`endif

   assign o_malformed_en  = (state_q == ST_CHECK);
   assign o_busy          = (state_q != ST_IDLE);
   assign o_err_valid     = (state_q == ST_REPORT);
   assign o_err_typ       = typ_q;
   assign o_last_dw       = last_dw_q;
   assign o_last_rcv_data = last_rcv_q;
   assign o_eop           = eop_q;
   assign o_rcv_done      = rcv_done_q;

endmodule : tl_rx_error_check_ctrl
